// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl_pkg
// Description : Shared definitions for the MD-unit issue sequencer. Holds the
//               MD opcodes, the busy-window lengths of the MD unit, and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package md_issue_ctrl_pkg;

  // MD opcodes as presented on e_md_op / md_op
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  // Busy cycles the MD unit reports after a start
  localparam logic [4:0] busy_mult = 5'd5;
  localparam logic [4:0] busy_div  = 5'd10;
  localparam logic [4:0] busy_zero = 5'd0;

  typedef enum logic [0:0] {
    MDS_IDLE = 1'b0,
    MDS_RUN  = 1'b1
  } md_state_t;

  // Long (multi-cycle) ops are 0..3, i.e. bit 2 clear
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Ops that write HI/LO without a start pulse
  function automatic logic is_mt_op(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage : md_issue_ctrl_pkg
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl
// Description : E-stage issue sequencer for the multiply/divide unit. Issues
//               start/op/operands, mirrors the unit's busy window with a
//               local countdown, stalls D-stage MD ops while an op is in
//               flight, returns mfhi/mflo data, and flags protocol errors.
// Ports       : clk, reset (async, active low)
//               d_md_valid                 - MD op present in D
//               e_md_valid/e_md_op/e_flush - MD op in E and its cancel
//               e_rs/e_rt                  - forwarded operands in E
//               md_start/md_op/md_d1/md_d2 - MD unit command
//               md_busy/md_hi/md_lo        - MD unit status and HI/LO
//               stall_d                    - freeze F/D, bubble into E
//               e_hilo_data                - mfhi/mflo result for E
//               proto_err                  - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter logic [4:0] MULT_LAT = busy_mult,
  parameter logic [4:0] DIV_LAT  = busy_div
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_valid,
  input  logic        e_md_valid,
  input  logic [2:0]  e_md_op,
  input  logic        e_flush,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        stall_d,
  output logic [31:0] e_hilo_data,
  output logic        proto_err
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        proto_err_q, proto_err_d;

  logic        accept;
  logic        running;
  logic        bad_issue;
  logic        busy_exp;

  always_comb begin
    accept    = e_md_valid & ~e_flush;
    running   = (state_q == MDS_RUN);
    // A long op or an HI/LO write reaching E while busy means the stall
    // upstream failed; block it from the MD unit and record the error.
    bad_issue = accept & running & (is_long_op(e_md_op) | is_mt_op(e_md_op));

    md_start  = accept & is_long_op(e_md_op) & ~running;
    // mfhi is the harmless idle op: the unit writes HI/LO on mthi/mtlo
    // without a start, so those must never leak out on idle cycles.
    md_op     = (accept & ~bad_issue) ? e_md_op : MD_MFHI;
    md_d1     = e_rs;
    md_d2     = e_rt;

    stall_d     = d_md_valid & (md_start | running);
    e_hilo_data = (e_md_op == MD_MFHI) ? md_hi : md_lo;

    // The unit is busy in the start cycle and while the countdown is live
    busy_exp    = md_start | (cnt_q != busy_zero);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDS_IDLE: begin
        if (md_start) begin
          // ops 2/3 (div/divu) have bit 1 set, ops 0/1 (mult/multu) do not
          cnt_d   = e_md_op[1] ? DIV_LAT : MULT_LAT;
          state_d = MDS_RUN;
        end
      end
      MDS_RUN: begin
        if (cnt_q == 5'd1) begin
          cnt_d   = busy_zero;
          state_d = MDS_IDLE;
        end else begin
          cnt_d   = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = MDS_IDLE;
        cnt_d   = busy_zero;
      end
    endcase

    proto_err_d = proto_err_q | bad_issue | (md_busy != busy_exp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MDS_IDLE;
      cnt_q       <= busy_zero;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

endmodule : md_issue_ctrl
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_ctrl
// Description : Directed testbench for md_issue_ctrl. A behavioural MD unit
//               answers the sequencer's commands; expected HI/LO read-back
//               values are queued when an op is issued and compared when the
//               matching mfhi/mflo is presented in E.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_md_valid, e_md_valid, e_flush;
  logic [2:0]  e_md_op;
  logic [31:0] e_rs, e_rt;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_d1, md_d2;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic        stall_d;
  logic [31:0] e_hilo_data;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .d_md_valid(d_md_valid), .e_md_valid(e_md_valid), .e_md_op(e_md_op),
    .e_flush(e_flush), .e_rs(e_rs), .e_rt(e_rt),
    .md_start(md_start), .md_op(md_op), .md_d1(md_d1), .md_d2(md_d2),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .stall_d(stall_d), .e_hilo_data(e_hilo_data), .proto_err(proto_err)
  );

  // ---------------- behavioural MD unit (responder) ----------------
  logic [4:0]  m_cnt;
  logic [31:0] m_hi, m_lo;
  assign md_busy = md_start | (m_cnt != 5'd0);
  assign md_hi   = m_hi;
  assign md_lo   = m_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= 5'd0;
    end else begin
      if (md_start) begin
        m_cnt <= md_op[1] ? 5'd10 : 5'd5;
        case (md_op)
          3'd0: {m_hi, m_lo} <= $signed({{32{md_d1[31]}}, md_d1}) *
                                $signed({{32{md_d2[31]}}, md_d2});
          3'd1: {m_hi, m_lo} <= {32'd0, md_d1} * {32'd0, md_d2};
          3'd2: if (md_d2 != 0) begin
                  m_lo <= $signed(md_d1) / $signed(md_d2);
                  m_hi <= $signed(md_d1) % $signed(md_d2);
                end
          3'd3: if (md_d2 != 0) begin
                  m_lo <= md_d1 / md_d2;
                  m_hi <= md_d1 % md_d2;
                end
          default: ;
        endcase
      end else begin
        if (m_cnt != 5'd0) m_cnt <= m_cnt - 5'd1;
        if (md_op == 3'd6) m_hi <= md_d1;
        if (md_op == 3'd7) m_lo <= md_d1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic ev, input logic fl,
                       input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    d_md_valid = dv; e_md_valid = ev; e_flush = fl;
    e_md_op = op; e_rs = rs; e_rt = rt;
  endtask

  task automatic bubble();
    drive(1'b1, 1'b0, 1'b0, 3'd4, 32'd0, 32'd0);
  endtask

  // Present mfhi/mflo in E (IDLE) and compare against the scoreboard
  task automatic read_hilo(input logic [2:0] op, input string tag);
    tick();
    drive(1'b0, 1'b1, 1'b0, op, 32'd0, 32'd0);
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, e_hilo_data);
    end else begin
      chk(tag, e_hilo_data, exp_q.pop_front());
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #3;
    chk("rst_start", {31'd0, md_start}, 32'd0);
    chk("rst_op", {29'd0, md_op}, 32'd4);
    chk("rst_stall", {31'd0, stall_d}, 32'd0);
    chk("rst_err", {31'd0, proto_err}, 32'd0);
    tick(); tick();
    reset = 1'b1;

    // ---------------- mult 3 * -2 ----------------
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd3, 32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFA);
    exp_q.push_back(32'hFFFF_FFFF);
    #2;
    chk("mult_start", {31'd0, md_start}, 32'd1);
    chk("mult_op", {29'd0, md_op}, 32'd0);
    chk("mult_stall_T", {31'd0, stall_d}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(); bubble(); #2;
      chk($sformatf("mult_nostart_T%0d", i), {31'd0, md_start}, 32'd0);
      chk($sformatf("mult_stall_T%0d", i), {31'd0, stall_d}, 32'd1);
    end
    read_hilo(3'd5, "mult_mflo");
    d_md_valid = 1'b1; #0;
    chk("mult_stall_T6", {31'd0, stall_d}, 32'd0);
    read_hilo(3'd4, "mult_mfhi");
    chk("mult_err", {31'd0, proto_err}, 32'd0);

    // ---------------- divu 17 / 5 ----------------
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'd17, 32'd5);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    #2;
    chk("divu_start", {31'd0, md_start}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick(); bubble(); #2;
      chk($sformatf("divu_stall_T%0d", i), {31'd0, stall_d}, 32'd1);
    end
    tick(); bubble(); #2;
    chk("divu_stall_T11", {31'd0, stall_d}, 32'd0);
    read_hilo(3'd4, "divu_mfhi");
    read_hilo(3'd5, "divu_mflo");

    // ---------------- flushed mthi / flushed mult ----------------
    tick();
    drive(1'b0, 1'b1, 1'b1, 3'd6, 32'h0000_DEAD, 32'd0);
    #2;
    chk("flush_mthi_op", {29'd0, md_op}, 32'd4);
    exp_q.push_back(32'd2);
    read_hilo(3'd4, "flush_mthi_hi");
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd9, 32'd9);
    #2;
    chk("flush_mult_start", {31'd0, md_start}, 32'd0);
    chk("flush_mult_stall", {31'd0, stall_d}, 32'd0);
    tick(); bubble(); #2;
    chk("flush_mult_idle", {31'd0, stall_d}, 32'd0);
    chk("flush_err", {31'd0, proto_err}, 32'd0);

    // ---------------- back-to-back mult ----------------
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd7, 32'd6);
    #2;
    chk("b2b_start1", {31'd0, md_start}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(); bubble(); #2;
      chk($sformatf("b2b_nostart_T%0d", i), {31'd0, md_start}, 32'd0);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'd1);
    #2;
    chk("b2b_start2_T6", {31'd0, md_start}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(); bubble(); #2;
    end
    chk("b2b_err", {31'd0, proto_err}, 32'd0);
    read_hilo(3'd5, "b2b_mflo");
    read_hilo(3'd4, "b2b_mfhi");

    // ---------------- long op while RUN ----------------
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'd100, 32'd7);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd2);
    #2;
    chk("lr_start1", {31'd0, md_start}, 32'd1);
    tick(); bubble(); #2;
    chk("lr_err_before", {31'd0, proto_err}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'd1, 32'd1);
    #2;
    chk("lr_nostart", {31'd0, md_start}, 32'd0);
    chk("lr_op", {29'd0, md_op}, 32'd4);
    for (int i = 3; i <= 10; i++) begin
      tick(); bubble(); #2;
      chk($sformatf("lr_err_T%0d", i), {31'd0, proto_err}, 32'd1);
    end
    read_hilo(3'd5, "lr_mflo");
    read_hilo(3'd4, "lr_mfhi");
    chk("lr_err_sticky", {31'd0, proto_err}, 32'd1);

    // ---------------- reset mid-RUN ----------------
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd5, 32'd5);
    #2;
    chk("rr_start", {31'd0, md_start}, 32'd1);
    tick(); bubble();
    tick(); bubble();
    tick(); bubble(); #2;
    chk("rr_stall_pre", {31'd0, stall_d}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rr_stall_async", {31'd0, stall_d}, 32'd0);
    chk("rr_err_async", {31'd0, proto_err}, 32'd0);
    chk("rr_op_async", {29'd0, md_op}, 32'd4);
    tick();
    reset = 1'b1;
    tick(); bubble(); #2;
    chk("rr_stall_post", {31'd0, stall_d}, 32'd0);
    tick(); #2;
    chk("rr_err_post", {31'd0, proto_err}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_md_issue_ctrl
`default_nettype wire
